// File: rtl/soc_audio_pkg.sv
// Shared audio definitions: I2S receiver defaults and frame-tracking states.
package soc_audio_pkg;

  localparam int unsigned I2S_SAMPLE_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_e;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the external I2S lines into the clk domain and flags sclk rising edges.
module i2s_rx_sync (
  input  logic clk,
  input  logic arst,
  input  logic i2s_sclk,
  input  logic i2s_lrclk,
  input  logic i2s_sdata,
  output logic sclk_rise,
  output logic lrclk_s,
  output logic sdata_s
);

  // sclk_q[1:0] is the synchronizer, sclk_q[2] the delayed copy for edge detect
  logic [2:0] sclk_q, sclk_d;
  logic [1:0] lrclk_q, lrclk_d;
  logic [1:0] sdata_q, sdata_d;

  always_comb begin
    sclk_d  = {sclk_q[1:0], i2s_sclk};
    lrclk_d = {lrclk_q[0], i2s_lrclk};
    sdata_d = {sdata_q[0], i2s_sdata};
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      sclk_q  <= '0;
      lrclk_q <= '0;
      sdata_q <= '0;
    end else begin
      sclk_q  <= sclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign lrclk_s   = lrclk_q[1];
  assign sdata_s   = sdata_q[1];

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: assembles MSB-aligned left/right words and hands the
// stereo pair to a valid/ready consumer, flagging dropped pairs as overrun.
module i2s_rx
  import soc_audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = I2S_SAMPLE_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    enable,
  input  logic                    i2s_sclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_sdata,
  output logic [SAMPLE_WIDTH-1:0] sample_l,
  output logic [SAMPLE_WIDTH-1:0] sample_r,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int unsigned CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_WIDTH);
  localparam logic [SAMPLE_WIDTH-1:0] MSB_ONE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic sclk_rise, lrclk_s, sdata_s;

  i2s_rx_sync u_sync (
    .clk       (clk),
    .arst      (arst),
    .i2s_sclk  (i2s_sclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata),
    .sclk_rise (sclk_rise),
    .lrclk_s   (lrclk_s),
    .sdata_s   (sdata_s)
  );

  i2s_rx_state_e          state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic                    lr_prev_q, lr_prev_d;
  logic [SAMPLE_WIDTH-1:0] sample_l_q, sample_l_d;
  logic [SAMPLE_WIDTH-1:0] sample_r_q, sample_r_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic [SAMPLE_WIDTH-1:0] word;
  logic                    pair_done;
  logic                    overrun_set;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_d      = left_q;
    lr_prev_d   = lr_prev_q;
    word        = shift_q;
    pair_done   = 1'b0;
    overrun_set = 1'b0;
    sample_l_d  = sample_l_q;
    sample_r_d  = sample_r_q;
    valid_d     = valid_q;

    if (sclk_rise) begin
      lr_prev_d = lrclk_s;
      // Bits land by position; once the counter saturates the mask shifts out to zero.
      if (sdata_s) begin
        word = shift_q | (MSB_ONE >> cnt_q);
      end
      shift_d = word;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end

      unique case (state_q)
        SYNC: begin
          if (lr_prev_q && !lrclk_s) begin
            state_d = LEFT;
            shift_d = '0;
            cnt_d   = '0;
          end
        end
        LEFT: begin
          if (!lr_prev_q && lrclk_s) begin
            left_d  = word;
            state_d = RIGHT;
            shift_d = '0;
            cnt_d   = '0;
          end
        end
        RIGHT: begin
          if (lr_prev_q && !lrclk_s) begin
            pair_done = 1'b1;
            state_d   = LEFT;
            shift_d   = '0;
            cnt_d     = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end

    if (!enable) begin
      state_d   = SYNC;
      cnt_d     = '0;
      pair_done = 1'b0;
    end

    if (pair_done) begin
      if (!valid_q || sample_ready) begin
        sample_l_d = left_q;
        sample_r_d = word;
        valid_d    = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    overrun_d = overrun_set | (overrun_q & ~overrun_clr);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= SYNC;
      cnt_q      <= '0;
      shift_q    <= '0;
      left_q     <= '0;
      lr_prev_q  <= 1'b0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      left_q     <= left_d;
      lr_prev_q  <= lr_prev_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives a Philips I2S bitstream into 16- and 24-bit receivers
// and compares every delivered pair against expectations built here.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int SCLK_HALF = 160;

  logic clk = 1'b0;
  logic arst, enable, i2s_sclk, i2s_lrclk, i2s_sdata, sample_ready, overrun_clr;
  logic [15:0] l16, r16;
  logic [23:0] l24, r24;
  logic v16, v24, ov16, ov24;

  always #5 clk = ~clk;

  i2s_rx dut16 (
    .clk(clk), .arst(arst), .enable(enable),
    .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .sample_l(l16), .sample_r(r16), .sample_valid(v16), .sample_ready(sample_ready),
    .overrun(ov16), .overrun_clr(overrun_clr)
  );

  i2s_rx #(.SAMPLE_WIDTH(24)) dut24 (
    .clk(clk), .arst(arst), .enable(enable),
    .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .sample_l(l24), .sample_r(r24), .sample_valid(v24), .sample_ready(sample_ready),
    .overrun(ov24), .overrun_clr(overrun_clr)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] q16_l[$], q16_r[$], q24_l[$], q24_r[$];
  logic [31:0] e16_l[$], e16_r[$], e24_l[$], e24_r[$];

  // Record every accepted pair as the consumer sees it.
  always @(negedge clk) begin
    if (!arst) begin
      if (v16 && sample_ready) begin
        q16_l.push_back(32'(l16));
        q16_r.push_back(32'(r16));
      end
      if (v24 && sample_ready) begin
        q24_l.push_back(32'(l24));
        q24_r.push_back(32'(r24));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: MSB-align an nbits slot word into a w-bit sample.
  function automatic logic [31:0] model(input logic [31:0] slot, input int nbits, input int w);
    logic [63:0] v;
    v = 64'(slot) & ((64'd1 << nbits) - 64'd1);
    if (nbits >= w) return 32'(v >> (nbits - w));
    else return 32'(v << (w - nbits));
  endfunction

  task automatic expect_model(input logic [31:0] l, input logic [31:0] r, input int nbits);
    e16_l.push_back(model(l, nbits, 16));
    e16_r.push_back(model(r, nbits, 16));
    e24_l.push_back(model(l, nbits, 24));
    e24_r.push_back(model(r, nbits, 24));
  endtask

  task automatic check_queues(input string name);
    chk({name, "_count16"}, 32'(q16_l.size()), 32'(e16_l.size()));
    for (int i = 0; i < e16_l.size() && i < q16_l.size(); i++) begin
      chk({name, "_l16"}, q16_l[i], e16_l[i]);
      chk({name, "_r16"}, q16_r[i], e16_r[i]);
    end
    chk({name, "_count24"}, 32'(q24_l.size()), 32'(e24_l.size()));
    for (int i = 0; i < e24_l.size() && i < q24_l.size(); i++) begin
      chk({name, "_l24"}, q24_l[i], e24_l[i]);
      chk({name, "_r24"}, q24_r[i], e24_r[i]);
    end
    q16_l.delete(); q16_r.delete(); q24_l.delete(); q24_r.delete();
    e16_l.delete(); e16_r.delete(); e24_l.delete(); e24_r.delete();
  endtask

  // Philips framing: each data bit trails its lrclk slot by one sclk period.
  logic pend = 1'b0;

  task automatic sbit(input logic lr, input logic nb);
    i2s_sclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdata = pend;
    pend      = nb;
    #(SCLK_HALF);
    i2s_sclk = 1'b1;
    #(SCLK_HALF);
  endtask

  task automatic send_bits(input logic lr, input logic [31:0] w, input int nbits,
                           input int from, input int to);
    logic [31:0] t;
    for (int k = from; k < to; k++) begin
      t = w >> (nbits - 1 - k);
      sbit(lr, t[0]);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
    send_bits(1'b0, l, nbits, 0, nbits);
    send_bits(1'b1, r, nbits, 0, nbits);
  endtask

  task automatic flush();
    sbit(1'b0, 1'b0);
    sbit(1'b0, 1'b0);
    i2s_sclk = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic begin_test(input int nbits);
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    pend = 1'b0;
    send_bits(1'b1, 32'h0, nbits, 0, nbits);
  endtask

  task automatic check_outputs(input string name, input logic [31:0] el16, input logic [31:0] er16,
                               input logic ev, input logic eov);
    @(negedge clk);
    chk({name, "_l16"}, 32'(l16), el16);
    chk({name, "_r16"}, 32'(r16), er16);
    chk({name, "_valid16"}, 32'(v16), 32'(ev));
    chk({name, "_overrun16"}, 32'(ov16), 32'(eov));
    chk({name, "_valid24"}, 32'(v24), 32'(ev));
    chk({name, "_overrun24"}, 32'(ov24), 32'(eov));
  endtask

  typedef struct {
    int          nbits;
    logic [31:0] l, r;
    logic [31:0] l16, r16, l24, r24;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [31:0] rl, rr;
    int          nb;

    tbl[0] = '{32, 32'h1234_0000, 32'hABCD_0000, 32'h1234, 32'hABCD, 32'h12_3400, 32'hAB_CD00};
    tbl[1] = '{16, 32'h8001, 32'h7FFE, 32'h8001, 32'h7FFE, 32'h80_0100, 32'h7F_FE00};
    tbl[2] = '{32, 32'hDEAD_BEEF, 32'h0123_4567, 32'hDEAD, 32'h0123, 32'hDE_ADBE, 32'h01_2345};
    tbl[3] = '{24, 32'hA5_A5C3, 32'h5A_5A3C, 32'hA5A5, 32'h5A5A, 32'hA5_A5C3, 32'h5A_5A3C};
    tbl[4] = '{8, 32'h81, 32'h7F, 32'h8100, 32'h7F00, 32'h81_0000, 32'h7F_0000};

    arst = 1'b1; enable = 1'b0; sample_ready = 1'b1; overrun_clr = 1'b0;
    i2s_sclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
    repeat (3) @(posedge clk);
    check_outputs("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("reset_l24", 32'(l24), 32'h0);
    @(posedge clk); #1 arst = 1'b0; enable = 1'b1;

    for (int i = 0; i < 5; i++) begin
      begin_test(tbl[i].nbits);
      send_frame(tbl[i].l, tbl[i].r, tbl[i].nbits);
      flush();
      e16_l.push_back(tbl[i].l16); e16_r.push_back(tbl[i].r16);
      e24_l.push_back(tbl[i].l24); e24_r.push_back(tbl[i].r24);
      check_queues($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_overrun", i), 32'(ov16 | ov24), 32'h0);
    end

    begin_test(32);
    for (int i = 0; i < 6; i++) begin
      nb = int'($urandom_range(8, 32));
      rl = $urandom;
      rr = $urandom;
      send_frame(rl, rr, nb);
      expect_model(rl, rr, nb);
    end
    flush();
    check_queues("random");

    // Consumer stalls across two frames: first pair held, second dropped.
    begin_test(32);
    @(posedge clk); #1 sample_ready = 1'b0;
    send_frame(32'h1111_0000, 32'h2222_0000, 32);
    send_frame(32'h3333_0000, 32'h4444_0000, 32);
    flush();
    check_outputs("overrun_hold", 32'h1111, 32'h2222, 1'b1, 1'b1);
    chk("overrun_hold_l24", 32'(l24), 32'h11_1100);
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    check_outputs("overrun_clr", 32'h1111, 32'h2222, 1'b1, 1'b0);

    // Disable keeps the held pair; a reset mid left-word then clears everything.
    begin_test(32);
    check_outputs("enable_keeps", 32'h1111, 32'h2222, 1'b1, 1'b0);
    send_bits(1'b0, 32'h7777_0000, 32, 0, 12);
    @(posedge clk); #1 arst = 1'b1;
    @(posedge clk); #1 arst = 1'b0;
    check_outputs("arst_mid", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("arst_mid_l24", 32'(l24), 32'h0);
    @(posedge clk); #1 sample_ready = 1'b1;
    send_bits(1'b0, 32'h7777_0000, 32, 12, 32);
    send_bits(1'b1, 32'h8888_0000, 32, 0, 32);
    send_frame(32'h9999_0000, 32'hAAAA_0000, 32);
    flush();
    expect_model(32'h9999_0000, 32'hAAAA_0000, 32);
    check_queues("arst_resume");

    // Stream begins mid right-word straight out of reset.
    @(posedge clk); #1 arst = 1'b1;
    @(posedge clk); #1 arst = 1'b0;
    pend = 1'b0;
    send_bits(1'b1, 32'hFFFF_FFFF, 32, 10, 32);
    send_frame(32'h5555_0000, 32'h6666_0000, 32);
    flush();
    expect_model(32'h5555_0000, 32'h6666_0000, 32);
    check_queues("mid_right_start");

    // One frame with the receiver disabled, then normal traffic.
    begin_test(32);
    @(posedge clk); #1 enable = 1'b0;
    send_frame(32'hBBBB_0000, 32'hCCCC_0000, 32);
    @(posedge clk); #1 enable = 1'b1;
    send_frame(32'h1357_9BDF, 32'h2468_ACE0, 32);
    send_frame(32'hFEDC_BA98, 32'h0F0F_F0F0, 32);
    flush();
    expect_model(32'h1357_9BDF, 32'h2468_ACE0, 32);
    expect_model(32'hFEDC_BA98, 32'h0F0F_F0F0, 32);
    check_queues("disable_frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 16: bits per channel word delivered, legal range 8..32.
REQ-002 clk  input  1  system clock; sole clock domain; frequency SHALL be at least 8x i2s_sclk.
REQ-003 arst  input  1  reset; synchronous, active-high, sampled on rising clk.
REQ-004 enable  input  1  receiver enable; low forces resynchronisation.
REQ-005 i2s_sclk  input  1  I2S bit clock from an external master; asynchronous to clk.
REQ-006 i2s_lrclk  input  1  word select; 0 = left, 1 = right; asynchronous to clk.
REQ-007 i2s_sdata  input  1  serial data, MSB first; asynchronous to clk.
REQ-008 sample_l  output  SAMPLE_WIDTH  left word of the held stereo pair.
REQ-009 sample_r  output  SAMPLE_WIDTH  right word of the held stereo pair.
REQ-010 sample_valid  output  1  held pair is valid.
REQ-011 sample_ready  input  1  consumer accepts the pair when sample_valid and sample_ready are both high on a rising clk.
REQ-012 overrun  output  1  sticky flag: a completed pair was dropped.
REQ-013 overrun_clr  input  1  single-cycle clear of overrun.

Function
REQ-014 i2s_sclk, i2s_lrclk and i2s_sdata SHALL each pass through a 2-FF synchronizer; an sclk rising edge is detected from the synchronized sclk and one delayed copy.
REQ-015 lrclk and sdata SHALL be sampled only on a detected sclk rising edge; all other clk cycles leave the shift state unchanged.
REQ-016 Format: Philips I2S; the MSB of a word is on the first sclk rising edge after the one at which the new lrclk level is first sampled.
REQ-017 The bit on the sclk edge at which an lrclk change is first sampled is the LSB of the previous word; it SHALL be shifted in before that word completes.
REQ-018 States: SYNC, LEFT, RIGHT.
REQ-019 SYNC -> LEFT on the first sampled lrclk 1->0 transition; all bits received in SYNC are discarded.
REQ-020 LEFT -> RIGHT on a sampled lrclk 0->1; the left word is latched internally.
REQ-021 RIGHT -> LEFT on a sampled lrclk 1->0; the pair completes.
REQ-022 Word assembly is MSB-aligned. Bits beyond SAMPLE_WIDTH in a word are ignored, with the bit counter saturating. Missing bits in a short word are zero-filled at the LSB end.
REQ-023 On pair completion with sample_valid low, or with sample_valid high and sample_ready high in the same cycle, the SHALL load sample_l/sample_r and set sample_valid on the next rising clk.
REQ-024 On pair completion with sample_valid high and sample_ready low, the new pair is dropped, the held pair is unchanged, and overrun is set.
REQ-025 Latency: sample_valid SHALL rise no later than 5 clk cycles after the raw sclk rising edge that completes the pair.
REQ-026 A handshake without a pair completion clears sample_valid on the next rising clk.
REQ-027 overrun_clr clears overrun; a simultaneous set wins.
REQ-028 enable low forces state SYNC and clears the bit counter. The held pair, sample_valid and overrun are unaffected, so the consumer may still drain the held pair.

Reset
REQ-029 On arst the block SHALL enter SYNC with all of the following cleared: synchronizers, edge detect, bit counter, shift registers, sample_l, sample_r, sample_valid and overrun.
REQ-030 arst asserted mid-word SHALL discard the partial word; no pair is emitted until a full left/right frame follows a fresh 1->0 lrclk transition.

Structure
REQ-031 Package soc_audio_pkg SHALL hold the SAMPLE_WIDTH default and the i2s_rx state enum (SYNC, LEFT, RIGHT).
REQ-032 Sub-module i2s_rx_sync SHALL contain the three 2-FF synchronizers and the sclk rising-edge detector, and SHALL output sclk_rise, lrclk_s and sdata_s.

Verification
REQ-033 Setup: clk 98.3 MHz, sclk 3.072 MHz, 32-bit slots. Send L=0x1234, R=0xABCD with sample_ready held high -> exactly one valid pulse, sample_l=0x1234, sample_r=0xABCD, overrun=0.
REQ-034 Start the bitstream mid right-word after reset -> no valid until the first complete left+right frame; the partial word is never output.
REQ-035 Hold sample_ready low across two frames (0x1111/0x2222, then 0x3333/0x4444) -> pair 0x1111/0x2222 is held and overrun=1. Pulse overrun_clr -> overrun=0.
REQ-036 SAMPLE_WIDTH=24 with 16-bit slots carrying L=0x8001 -> sample_l=0x800100. With 32-bit slots carrying 0xDEADBEEF -> sample_l=0xDEADBE.
REQ-037 Assert arst for 1 clk mid left-word -> all outputs are 0 on the next clk, and the next valid pair comes only from the following full frame.
REQ-038 Deassert enable for one frame, then reassert -> no pairs during the disabled frame, and correct data resumes after the next 1->0 lrclk transition.
